rcfg_ctx_seq: RTL and testbench

Reconfiguration context sequencer for the PEA. It sits directly upstream of the PEA configuration-selection stage and drives the context address that picks which of the KMEM_SIZE stored configuration words each PE executes in a given cycle. Once started, it steps cyclically through contexts 0..ctx_last for a programmed number of iterations, honouring a per-cycle step enable. It then waits a fixed drain time and signals completion.

---
 rtl/pea_pkg.sv | 16 +
 rtl/rcfg_ctx_seq.sv | 136 +++++++++++++
 tb/tb_rcfg_ctx_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pea_pkg.sv
// Shared PEA definitions: context memory geometry and the
// context sequencer state encoding.
package pea_pkg;

    localparam int KMEM_SIZE       = 4;
    localparam int N_CFG_ADDR_BITS = $clog2(KMEM_SIZE);
    localparam int ITER_W          = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } ctx_seq_state_e;

endpackage

// File: rtl/rcfg_ctx_seq.sv
// Reconfiguration context sequencer: steps the PEA context address
// through 0..ctx_last for n_iter passes, drains, then pulses done.
//
// Ports:
//   clk_i, rst_i         clock, async active-high reset
//   start_i, abort_i     start request (IDLE only), abort (highest priority)
//   ctx_last_i, n_iter_i loop bound and pass count, latched at start
//   step_en_i            PEA can consume a context this cycle
//   rcfg_ctrl_addr_o     registered context address to the cfg selector
//   pea_en_o             addressed context executes this cycle
//   busy_o, done_o       RUN/DRAIN indicator, one-cycle completion pulse
//   iter_cnt_o           completed passes in the current run
module rcfg_ctx_seq #(
    parameter int KMEM_SIZE       = pea_pkg::KMEM_SIZE,
    parameter int N_CFG_ADDR_BITS = pea_pkg::N_CFG_ADDR_BITS,
    parameter int ITER_W          = pea_pkg::ITER_W,
    parameter int DRAIN_CYCLES    = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [N_CFG_ADDR_BITS-1:0] ctx_last_i,
    input  logic [ITER_W-1:0]          n_iter_i,
    input  logic                       step_en_i,
    output logic [N_CFG_ADDR_BITS-1:0] rcfg_ctrl_addr_o,
    output logic                       pea_en_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [ITER_W-1:0]          iter_cnt_o
);
    import pea_pkg::*;

    localparam logic [N_CFG_ADDR_BITS-1:0] CTX_MAX =
        N_CFG_ADDR_BITS'(KMEM_SIZE - 1);
    localparam logic [4:0] DRAIN_LEN = 5'(DRAIN_CYCLES);

    ctx_seq_state_e             state_q, state_d;
    logic [N_CFG_ADDR_BITS-1:0] addr_q, addr_d;
    logic [N_CFG_ADDR_BITS-1:0] last_q, last_d;
    logic [ITER_W-1:0]          iter_q, iter_d;
    logic [ITER_W-1:0]          niter_q, niter_d;
    logic [3:0]                 drain_q, drain_d;
    logic                       busy_q, done_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        iter_d  = iter_q;
        niter_d = niter_q;
        drain_d = drain_q;
        if (abort_i) begin
            state_d = IDLE;
            addr_d  = '0;
            drain_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (n_iter_i != '0) begin
                            state_d = RUN;
                            // Non power-of-two memories cannot hold
                            // every encodable address.
                            last_d  = (ctx_last_i > CTX_MAX) ?
                                      CTX_MAX : ctx_last_i;
                            niter_d = n_iter_i;
                            addr_d  = '0;
                            iter_d  = '0;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                RUN: begin
                    if (step_en_i) begin
                        if (addr_q == last_q) begin
                            addr_d = '0;
                            iter_d = iter_q + ITER_W'(1);
                            if (iter_q == niter_q - ITER_W'(1)) begin
                                state_d = DRAIN;
                                drain_d = '0;
                            end
                        end else begin
                            addr_d = addr_q + N_CFG_ADDR_BITS'(1);
                        end
                    end
                end
                DRAIN: begin
                    // A zero drain length still spends one cycle here.
                    if ({1'b0, drain_q} + 5'd1 >= DRAIN_LEN) begin
                        state_d = DONE;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + 4'd1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            iter_q  <= '0;
            niter_q <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            iter_q  <= iter_d;
            niter_q <= niter_d;
            drain_q <= drain_d;
            busy_q  <= (state_d == RUN) || (state_d == DRAIN);
            done_q  <= (state_d == DONE);
        end
    end

    assign rcfg_ctrl_addr_o = addr_q;
    assign pea_en_o         = (state_q == RUN) & step_en_i;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign iter_cnt_o       = iter_q;

endmodule

// File: tb/tb_rcfg_ctx_seq.sv
// Bench for rcfg_ctx_seq: directed scenarios with literal
// expectations plus random traffic against a step-count model.
module tb_rcfg_ctx_seq;
    localparam int KM = 6;
    localparam int AW = 3;
    localparam int IW = 16;
    localparam int DC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          step_en = 1'b0;
    logic [AW-1:0] ctx_last = '0;
    logic [IW-1:0] n_iter = '0;
    logic [AW-1:0] addr;
    logic          pea_en, busy, done;
    logic [IW-1:0] iter_cnt;

    rcfg_ctx_seq #(
        .KMEM_SIZE(KM), .N_CFG_ADDR_BITS(AW),
        .ITER_W(IW), .DRAIN_CYCLES(DC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .ctx_last_i(ctx_last), .n_iter_i(n_iter), .step_en_i(step_en),
        .rcfg_ctrl_addr_o(addr), .pea_en_o(pea_en), .busy_o(busy),
        .done_o(done), .iter_cnt_o(iter_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: phase 0 idle, 1 run, 2 drain, 3 done. A run is a count of
    // consumed contexts k; address and pass number follow from k.
    int m_ph = 0, m_k = 0, m_len = 1, m_n = 0, m_dl = 0, m_iter = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = 0; m_k = 0; m_len = 1; m_n = 0; m_dl = 0; m_iter = 0;
        end else if (abort) begin
            m_ph = 0;
        end else begin
            case (m_ph)
                0: if (start) begin
                    if (n_iter == 0) m_ph = 3;
                    else begin
                        m_ph = 1; m_k = 0; m_iter = 0; m_n = n_iter;
                        m_len = ((int'(ctx_last) > KM - 1) ? KM - 1 : int'(ctx_last)) + 1;
                    end
                end
                1: if (step_en) begin
                    m_k++;
                    m_iter = m_k / m_len;
                    if (m_k == m_n * m_len) begin
                        m_ph = 2;
                        m_dl = (DC > 1) ? DC : 1;
                    end
                end
                2: begin
                    m_dl--;
                    if (m_dl == 0) m_ph = 3;
                end
                default: m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        #2;
        chk("addr", addr, (m_ph == 1) ? m_k % m_len : 0);
        chk("pea_en", pea_en, (m_ph == 1) && step_en);
        chk("busy", busy, (m_ph == 1) || (m_ph == 2));
        chk("done", done, m_ph == 3);
        chk("iter_cnt", iter_cnt, m_iter);
    end

    task automatic go(input logic [AW-1:0] cl, input logic [IW-1:0] n,
                      input bit stall, output int cyc, output int en_cnt,
                      output int maxa, output bit busy_seen);
        @(negedge clk);
        start = 1'b1; ctx_last = cl; n_iter = n; step_en = 1'b1;
        cyc = 0; en_cnt = 0; maxa = 0; busy_seen = 1'b0;
        while (1) begin
            #2;
            cyc++;
            if (pea_en) en_cnt++;
            if (busy) busy_seen = 1'b1;
            if (int'(addr) > maxa) maxa = int'(addr);
            if (done) break;
            if (cyc > 200) begin
                chk("go_timeout", 0, 1);
                break;
            end
            @(negedge clk);
            start = 1'b0;
            step_en = stall ? ((cyc % 2) == 1) : 1'b1;
        end
        @(negedge clk);
        start = 1'b0; step_en = 1'b1;
    endtask

    int cyc, en, mx;
    bit bs;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_addr", addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_iter", iter_cnt, 0);
        chk("rst_pea_en", pea_en, 0);
        rst = 1'b0;
        @(negedge clk);

        go(3'd2, 16'd3, 1'b0, cyc, en, mx, bs);
        chk("basic_len", cyc, 13);
        chk("basic_en", en, 9);
        chk("basic_max", mx, 2);
        #2 chk("basic_iter", iter_cnt, 3);

        go(3'd2, 16'd3, 1'b1, cyc, en, mx, bs);
        chk("stall_len", cyc, 21);
        chk("stall_en", en, 9);

        go(3'd2, 16'd0, 1'b0, cyc, en, mx, bs);
        chk("zero_len", cyc, 2);
        chk("zero_en", en, 0);
        chk("zero_busy", bs, 0);

        go(3'd7, 16'd1, 1'b0, cyc, en, mx, bs);
        chk("clamp_max", mx, KM - 1);
        chk("clamp_len", cyc, 10);

        go(3'd0, 16'd5, 1'b0, cyc, en, mx, bs);
        chk("c0_max", mx, 0);
        chk("c0_en", en, 5);
        chk("c0_len", cyc, 9);
        #2 chk("c0_iter", iter_cnt, 5);

        // Abort while addr==1.
        @(negedge clk);
        start = 1'b1; ctx_last = 3'd2; n_iter = 16'd3; step_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (addr == 3'd1) break;
            @(negedge clk);
        end
        chk("abort_at1", addr, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #2;
        chk("abort_busy", busy, 0);
        chk("abort_addr", addr, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2 if (done) chk("abort_no_done", done, 0);
        end
        go(3'd2, 16'd3, 1'b0, cyc, en, mx, bs);
        chk("post_abort_len", cyc, 13);

        // Reset in DRAIN.
        @(negedge clk);
        start = 1'b1; ctx_last = 3'd0; n_iter = 16'd1; step_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_ph == 2) break;
            @(negedge clk);
        end
        chk("reach_drain", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstm_busy", busy, 0);
        chk("rstm_done", done, 0);
        chk("rstm_iter", iter_cnt, 0);
        chk("rstm_pea_en", pea_en, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start    = ($urandom % 4) == 0;
            abort    = ($urandom % 40) == 0;
            step_en  = ($urandom % 4) != 0;
            ctx_last = AW'($urandom);
            n_iter   = IW'($urandom % 4);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
